// File: rtl/calc_input_conditioner_if.sv
// Board-side bundle for the calculator front end: raw buttons/switches in,
// clean strobes, digit vector and operator levels out.
interface calc_input_conditioner_if;
  logic       set_raw;
  logic       append_raw;
  logic [9:0] key_raw;
  logic [3:0] op_raw;

  logic       set;
  logic       append;
  logic [9:0] KEY;
  logic [3:0] digit;
  logic       key_valid;
  logic       key_err;
  logic       Add;
  logic       Sub;
  logic       Mul;
  logic       Div;
  logic       op_err;

  modport slave (
    input  set_raw, append_raw, key_raw, op_raw,
    output set, append, KEY, digit, key_valid, key_err,
    output Add, Sub, Mul, Div, op_err
  );

  modport master (
    output set_raw, append_raw, key_raw, op_raw,
    input  set, append, KEY, digit, key_valid, key_err,
    input  Add, Sub, Mul, Div, op_err
  );
endinterface

// File: rtl/calc_input_conditioner.sv
// Input front end for the LCD calculator: synchronizes and debounces raw board
// inputs, then derives edge strobes and validated one-hot digit/operator groups.
module calc_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input logic                     clk,
  input logic                     rst_n,
  calc_input_conditioner_if.slave io
);

  localparam int NBITS = 16;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Raw bit map: 0 = set, 1 = append, 2..11 = digit keys, 12..15 = {Div,Mul,Sub,Add}
  logic [NBITS-1:0] raw_vec;
  logic [NBITS-1:0] sync1_reg;
  logic [NBITS-1:0] sync2_reg;
  logic [NBITS-1:0] stable_vec;

  assign raw_vec = {io.op_raw, io.key_raw, io.append_raw, io.set_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_vec;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debouncer: a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any bounce back restarts the count.
  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_deb
      logic             stable_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stable_reg <= 1'b0;
          cnt_reg    <= '0;
        end else if (sync2_reg[gi] == stable_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == TERM_CNT) begin
          stable_reg <= sync2_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign stable_vec[gi] = stable_reg;
    end
  endgenerate

  logic       set_s;
  logic       app_s;
  logic [9:0] key_s;
  logic [3:0] op_s;

  assign set_s = stable_vec[0];
  assign app_s = stable_vec[1];
  assign key_s = stable_vec[11:2];
  assign op_s  = stable_vec[15:12];

  // Strobe generation
  logic set_arm_reg, set_arm_next;
  logic app_arm_reg, app_arm_next;
  logic set_reg, set_next;
  logic app_reg, app_next;
  logic set_fire, app_rise;
  logic key_err_reg;

  always_comb begin
    set_fire = set_s & set_arm_reg;
    app_rise = app_s & app_arm_reg;
    set_next = set_fire;
    // A simultaneous SET or a key conflict consumes the append press outright.
    app_next = app_rise & ~set_fire & ~key_err_reg;
    set_arm_next = ~set_s | (set_arm_reg & ~set_fire);
    app_arm_next = ~app_s | (app_arm_reg & ~app_rise);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_arm_reg <= 1'b0;
      app_arm_reg <= 1'b0;
      set_reg     <= 1'b0;
      app_reg     <= 1'b0;
    end else begin
      set_arm_reg <= set_arm_next;
      app_arm_reg <= app_arm_next;
      set_reg     <= set_next;
      app_reg     <= app_next;
    end
  end

  // Key group validation
  logic [3:0] key_cnt;
  logic [3:0] key_idx;
  logic [9:0] key_reg, key_next;
  logic [3:0] digit_reg, digit_next;
  logic       key_valid_reg, key_valid_next;
  logic       key_err_next;

  always_comb begin
    key_cnt = '0;
    key_idx = '0;
    for (int i = 0; i < 10; i++) begin
      key_cnt = key_cnt + {3'b000, key_s[i]};
      if (key_s[i]) key_idx = 4'(i);
    end
  end

  always_comb begin
    key_next       = key_reg;
    digit_next     = digit_reg;
    key_valid_next = key_valid_reg;
    key_err_next   = 1'b0;
    if (key_cnt == 4'd0) begin
      key_next       = '0;
      digit_next     = '0;
      key_valid_next = 1'b0;
    end else if (key_cnt == 4'd1) begin
      key_next       = key_s;
      digit_next     = key_idx;
      key_valid_next = 1'b1;
    end else begin
      // Conflicting keys: keep presenting the last valid digit.
      key_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg       <= '0;
      digit_reg     <= '0;
      key_valid_reg <= 1'b0;
      key_err_reg   <= 1'b0;
    end else begin
      key_reg       <= key_next;
      digit_reg     <= digit_next;
      key_valid_reg <= key_valid_next;
      key_err_reg   <= key_err_next;
    end
  end

  // Operator group validation: conflicts blank all four levels.
  logic [2:0] op_cnt;
  logic [3:0] op_reg, op_next;
  logic       op_err_reg, op_err_next;

  always_comb begin
    op_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      op_cnt = op_cnt + {2'b00, op_s[i]};
    end
    op_next     = (op_cnt == 3'd1) ? op_s : 4'b0000;
    op_err_next = (op_cnt > 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      op_err_reg <= 1'b0;
    end else begin
      op_reg     <= op_next;
      op_err_reg <= op_err_next;
    end
  end

  assign io.set       = set_reg;
  assign io.append    = app_reg;
  assign io.KEY       = key_reg;
  assign io.digit     = digit_reg;
  assign io.key_valid = key_valid_reg;
  assign io.key_err   = key_err_reg;
  assign io.Add       = op_reg[0];
  assign io.Sub       = op_reg[1];
  assign io.Mul       = op_reg[2];
  assign io.Div       = op_reg[3];
  assign io.op_err    = op_err_reg;

endmodule

// File: tb/tb_calc_input_conditioner.sv
// Directed bench for calc_input_conditioner with a 4-cycle debounce window;
// inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_calc_input_conditioner;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   set_cnt  = 0;
  int   app_cnt  = 0;
  int   set_base;
  int   app_base;

  calc_input_conditioner_if bus ();

  calc_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters see the value held during the cycle before each rising edge.
  always @(posedge clk) begin
    if (bus.set) set_cnt++;
    if (bus.append) app_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.set_raw    = 1'b1;
    bus.append_raw = 1'b1;
    bus.key_raw    = 10'h3FF;
    bus.op_raw     = 4'hF;

    // 1: all outputs low in reset, set pulses 7 cycles after release
    step(3);
    check("rst_set", 32'(bus.set), 32'd0);
    check("rst_append", 32'(bus.append), 32'd0);
    check("rst_KEY", 32'(bus.KEY), 32'd0);
    check("rst_key_err", 32'(bus.key_err), 32'd0);
    check("rst_op_err", 32'(bus.op_err), 32'd0);
    check("rst_Add", 32'(bus.Add), 32'd0);
    set_base = set_cnt;
    app_base = app_cnt;
    rst_n = 1'b1;
    step(6);
    check("t1_set_early", 32'(bus.set), 32'd0);
    step(1);
    check("t1_set_pulse", 32'(bus.set), 32'd1);
    check("t1_key_err", 32'(bus.key_err), 32'd1);
    check("t1_KEY_hold0", 32'(bus.KEY), 32'd0);
    check("t1_op_err", 32'(bus.op_err), 32'd1);
    step(1);
    check("t1_set_once", 32'(bus.set), 32'd0);
    step(5);
    check("t1_set_count", 32'(set_cnt - set_base), 32'd1);
    check("t1_app_count", 32'(app_cnt - app_base), 32'd0);

    bus.set_raw    = 1'b0;
    bus.append_raw = 1'b0;
    bus.key_raw    = '0;
    bus.op_raw     = '0;
    step(10);
    check("idle_key_err", 32'(bus.key_err), 32'd0);

    // 2: bouncing SET never qualifies, then one pulse 7 cycles after last edge
    set_base = set_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.set_raw = ~bus.set_raw;
      step(1);
    end
    bus.set_raw = 1'b1;
    check("t2_no_pulse_bounce", 32'(set_cnt - set_base), 32'd0);
    step(6);
    check("t2_set_early", 32'(bus.set), 32'd0);
    step(1);
    check("t2_set_pulse", 32'(bus.set), 32'd1);
    step(20);
    check("t2_set_held_count", 32'(set_cnt - set_base), 32'd1);
    bus.set_raw = 1'b0;
    step(8);

    // 3: single digit 2, then append accepted
    bus.key_raw = 10'b0000000100;
    step(7);
    check("t3_KEY", 32'(bus.KEY), 32'h004);
    check("t3_digit", 32'(bus.digit), 32'd2);
    check("t3_key_valid", 32'(bus.key_valid), 32'd1);
    check("t3_key_err", 32'(bus.key_err), 32'd0);
    app_base = app_cnt;
    bus.append_raw = 1'b1;
    step(7);
    check("t3_append_pulse", 32'(bus.append), 32'd1);
    step(5);
    check("t3_app_count", 32'(app_cnt - app_base), 32'd1);
    bus.append_raw = 1'b0;
    step(8);

    // 4: two keys -> error, KEY holds, append suppressed; then digit 3
    bus.key_raw = 10'b0000001100;
    step(7);
    check("t4_key_err", 32'(bus.key_err), 32'd1);
    check("t4_KEY_hold", 32'(bus.KEY), 32'h004);
    check("t4_digit_hold", 32'(bus.digit), 32'd2);
    app_base = app_cnt;
    bus.append_raw = 1'b1;
    step(12);
    check("t4_app_suppressed", 32'(app_cnt - app_base), 32'd0);
    bus.append_raw = 1'b0;
    step(8);
    bus.key_raw = 10'b0000001000;
    step(7);
    check("t4_KEY", 32'(bus.KEY), 32'h008);
    check("t4_digit", 32'(bus.digit), 32'd3);
    check("t4_key_err_clr", 32'(bus.key_err), 32'd0);
    check("t4_key_valid", 32'(bus.key_valid), 32'd1);

    // 5: simultaneous SET and APPEND -> only set; re-press append -> one pulse
    set_base = set_cnt;
    app_base = app_cnt;
    bus.set_raw    = 1'b1;
    bus.append_raw = 1'b1;
    step(7);
    check("t5_set_pulse", 32'(bus.set), 32'd1);
    check("t5_append_none", 32'(bus.append), 32'd0);
    step(10);
    check("t5_set_count", 32'(set_cnt - set_base), 32'd1);
    check("t5_app_count", 32'(app_cnt - app_base), 32'd0);
    bus.append_raw = 1'b0;
    step(8);
    bus.append_raw = 1'b1;
    step(7);
    check("t5_append_pulse", 32'(bus.append), 32'd1);
    step(5);
    check("t5_app_count2", 32'(app_cnt - app_base), 32'd1);
    bus.set_raw    = 1'b0;
    bus.append_raw = 1'b0;
    step(8);

    // 6: operator conflict, then Add alone
    bus.op_raw = 4'b0011;
    step(7);
    check("t6_op_err", 32'(bus.op_err), 32'd1);
    check("t6_Add_blank", 32'(bus.Add), 32'd0);
    check("t6_Sub_blank", 32'(bus.Sub), 32'd0);
    bus.op_raw = 4'b0001;
    step(7);
    check("t6_Add", 32'(bus.Add), 32'd1);
    check("t6_Sub", 32'(bus.Sub), 32'd0);
    check("t6_op_err_clr", 32'(bus.op_err), 32'd0);

    // 6b: reset partway through a SET debounce loses the partial count
    set_base = set_cnt;
    bus.set_raw = 1'b1;
    step(3);
    rst_n = 1'b0;
    step(1);
    check("t6_rst_Add", 32'(bus.Add), 32'd0);
    rst_n = 1'b1;
    step(6);
    check("t6_no_early_set", 32'(set_cnt - set_base), 32'd0);
    check("t6_set_early", 32'(bus.set), 32'd0);
    step(1);
    check("t6_set_pulse", 32'(bus.set), 32'd1);
    step(3);
    check("t6_set_count", 32'(set_cnt - set_base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
